// File: rtl/alu_exec_queue_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_queue_pkg
// Shared defines for the integer execute unit: opcode encoding, default ROB
// tag width and the result value used for opcodes the ALU does not decode.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_exec_queue_pkg;

   localparam int OP_W      = 6;
   localparam int ROB_W_DEF = 4;

   // Result for unrecognised opcodes; sliced down to XLEN by the consumer.
   localparam logic [63:0] NULL_ANS = 64'd0;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 6'd0,
      OP_ADD   = 6'd1,
      OP_ADDI  = 6'd2,
      OP_SUB   = 6'd3,
      OP_XOR   = 6'd4,
      OP_XORI  = 6'd5,
      OP_OR    = 6'd6,
      OP_ORI   = 6'd7,
      OP_AND   = 6'd8,
      OP_ANDI  = 6'd9,
      OP_SLL   = 6'd10,
      OP_SLLI  = 6'd11,
      OP_SRL   = 6'd12,
      OP_SRLI  = 6'd13,
      OP_SRA   = 6'd14,
      OP_SRAI  = 6'd15,
      OP_SLT   = 6'd16,
      OP_SLTI  = 6'd17,
      OP_SLTU  = 6'd18,
      OP_SLTIU = 6'd19,
      OP_BEQ   = 6'd20,
      OP_BNE   = 6'd21,
      OP_BLT   = 6'd22,
      OP_BGE   = 6'd23,
      OP_BLTU  = 6'd24,
      OP_BGEU  = 6'd25,
      OP_JALR  = 6'd26
   } opcode_e;

endpackage

// File: rtl/alu_exec_queue_if.sv
// ---------------------------------------------------------------------------
// alu_exec_queue_if
// Issue and broadcast signals of the execute unit.
//   in_valid/in_ready/in_opcode/in_val1/in_val2/in_rob : issue from the RS
//   out_valid/out_grant/out_ans/out_rob/out_op         : head result to CDB
//   out_count                                          : queue occupancy
// slave  = the execute unit; master = RS / CDB arbiter side.
// ---------------------------------------------------------------------------
interface alu_exec_queue_if
   import alu_exec_queue_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int ROB_W = ROB_W_DEF,
   parameter int DEPTH = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [OP_W-1:0]         in_opcode;
   logic [XLEN-1:0]         in_val1;
   logic [XLEN-1:0]         in_val2;
   logic [ROB_W-1:0]        in_rob;
   logic                    out_valid;
   logic                    out_grant;
   logic [XLEN-1:0]         out_ans;
   logic [ROB_W-1:0]        out_rob;
   logic [OP_W-1:0]         out_op;
   logic [$clog2(DEPTH):0]  out_count;

   modport slave (
      input  in_valid, in_opcode, in_val1, in_val2, in_rob, out_grant,
      output in_ready, out_valid, out_ans, out_rob, out_op, out_count
   );

   modport master (
      output in_valid, in_opcode, in_val1, in_val2, in_rob, out_grant,
      input  in_ready, out_valid, out_ans, out_rob, out_op, out_count
   );
endinterface

// File: rtl/alu_exec_queue_alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational integer ALU: {opcode, val1, val2} -> ans.
//   opcode : shared opcode encoding
//   val1   : first operand
//   val2   : second operand / immediate; low $clog2(XLEN) bits = shift amount
//   ans    : result; branches give 1 when taken, unknown opcodes give 0
// ---------------------------------------------------------------------------
module alu_core
   import alu_exec_queue_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic [OP_W-1:0] opcode,
   input  logic [XLEN-1:0] val1,
   input  logic [XLEN-1:0] val2,
   output logic [XLEN-1:0] ans
);
   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic            lt_s;
   logic            lt_u;
   logic            eq;

   assign shamt = val2[SHW-1:0];
   assign sum   = val1 + val2;
   assign diff  = val1 - val2;
   assign lt_s  = $signed(val1) < $signed(val2);
   assign lt_u  = val1 < val2;
   assign eq    = val1 == val2;

   always_comb begin
      ans = NULL_ANS[XLEN-1:0];
      case (opcode)
         OP_ADD,  OP_ADDI:  ans = sum;
         OP_SUB:            ans = diff;
         OP_XOR,  OP_XORI:  ans = val1 ^ val2;
         OP_OR,   OP_ORI:   ans = val1 | val2;
         OP_AND,  OP_ANDI:  ans = val1 & val2;
         OP_SLL,  OP_SLLI:  ans = val1 << shamt;
         OP_SRL,  OP_SRLI:  ans = val1 >> shamt;
         OP_SRA,  OP_SRAI:  ans = XLEN'($signed(val1) >>> shamt);
         OP_SLT,  OP_SLTI:  ans = XLEN'(lt_s);
         OP_SLTU, OP_SLTIU: ans = XLEN'(lt_u);
         OP_BEQ:            ans = XLEN'(eq);
         OP_BNE:            ans = XLEN'(!eq);
         OP_BLT:            ans = XLEN'(lt_s);
         OP_BGE:            ans = XLEN'(!lt_s);
         OP_BLTU:           ans = XLEN'(lt_u);
         OP_BGEU:           ans = XLEN'(!lt_u);
         // Jump target must be halfword aligned: clear bit 0.
         OP_JALR:           ans = sum & {{(XLEN-1){1'b1}}, 1'b0};
         default:           ans = NULL_ANS[XLEN-1:0];
      endcase
   end
endmodule

// File: rtl/alu_exec_queue.sv
// ---------------------------------------------------------------------------
// alu_exec_queue
// Execute unit between reservation station and CDB. Computes one op per
// cycle and queues {ans, rob, opcode} in a DEPTH-entry in-order FIFO until
// the CDB grants the head.
//   clk_in   : clock, rising edge
//   rst_n_in : synchronous active-low reset
//   rdy_in   : global enable; low freezes all state including flush
//   flush_in : discard queued and incoming ops
//   bus      : issue / broadcast signals (slave modport)
// ---------------------------------------------------------------------------
module alu_exec_queue
   import alu_exec_queue_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int ROB_W = ROB_W_DEF,
   parameter int DEPTH = 4
)(
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 flush_in,
   alu_exec_queue_if.slave      bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic [XLEN-1:0]  ans_mem [DEPTH];
   logic [ROB_W-1:0] rob_mem [DEPTH];
   logic [OP_W-1:0]  op_mem  [DEPTH];

   logic [XLEN-1:0]  alu_ans;
   logic             in_ready_int;
   logic             out_valid_int;
   logic             push;
   logic             pop;

   alu_core #(.XLEN(XLEN)) u_alu_core (
      .opcode (bus.in_opcode),
      .val1   (bus.in_val1),
      .val2   (bus.in_val2),
      .ans    (alu_ans)
   );

   // Ready depends only on occupancy, never on out_grant, so a full queue
   // refuses a push even in a cycle where the head is being popped.
   assign in_ready_int  = rdy_in && rst_n_in && (count_reg < CNT_W'(DEPTH));
   assign out_valid_int = count_reg != '0;
   assign push = bus.in_valid && in_ready_int && rdy_in && !flush_in;
   assign pop  = out_valid_int && bus.out_grant && rdy_in && !flush_in;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush_in) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (push) tail_next = tail_reg + PTR_W'(1);
         if (pop)  head_next = head_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   // rdy_in gates the whole update so a flush waits for the unit to resume.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (rdy_in) begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Storage entries are cleared on reset so the head reads 0 while empty.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk_in) begin
            if (!rst_n_in) begin
               ans_mem[gi] <= '0;
               rob_mem[gi] <= '0;
               op_mem[gi]  <= '0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
               ans_mem[gi] <= alu_ans;
               rob_mem[gi] <= bus.in_rob;
               op_mem[gi]  <= bus.in_opcode;
            end
         end
      end
   endgenerate

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_int;
   assign bus.out_ans   = ans_mem[head_reg];
   assign bus.out_rob   = rob_mem[head_reg];
   assign bus.out_op    = op_mem[head_reg];
   assign bus.out_count = count_reg;
endmodule

// File: tb/tb_alu_exec_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_queue
// Directed self-checking bench for alu_exec_queue (XLEN=32, ROB_W=4, DEPTH=4).
// ---------------------------------------------------------------------------
module tb_alu_exec_queue;
   import alu_exec_queue_pkg::*;

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;
   logic rdy_in   = 1'b1;
   logic flush_in = 1'b0;

   int total = 0;
   int bad   = 0;

   alu_exec_queue_if #(.XLEN(32), .ROB_W(4), .DEPTH(4)) bus ();

   alu_exec_queue #(.XLEN(32), .ROB_W(4), .DEPTH(4)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] rob);
      bus.in_valid  = v;
      bus.in_opcode = op;
      bus.in_val1   = a;
      bus.in_val2   = b;
      bus.in_rob    = rob;
   endtask

   // Single op into an empty queue with out_grant high: visible after one
   // edge, popped on the next.
   task automatic issue_check(input string tag, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] rob,
                              input logic [31:0] exp);
      drive(1'b1, op, a, b, rob);
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_ans"},   bus.out_ans, exp);
      chk({tag, "_rob"},   32'(bus.out_rob), 32'(rob));
      tick();
   endtask

   initial begin
      drive(1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
      bus.out_grant = 1'b0;

      // ---------------- reset ----------------
      tick();
      tick();
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_ans",   bus.out_ans,        32'd0);
      chk("rst_out_rob",   32'(bus.out_rob),   32'd0);
      chk("rst_out_op",    32'(bus.out_op),    32'd0);
      chk("rst_out_count", 32'(bus.out_count), 32'd0);
      rst_n_in = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // ---------------- ADD 5+7, tag 3 ----------------
      bus.out_grant = 1'b1;
      drive(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
      tick();
      bus.in_valid = 1'b0;
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_ans",   bus.out_ans,        32'd12);
      chk("add_rob",   32'(bus.out_rob),   32'd3);
      chk("add_op",    32'(bus.out_op),    32'(OP_ADD));
      tick();
      chk("add_drained", 32'(bus.out_valid), 32'd0);

      // ---------------- ALU vectors ----------------
      issue_check("sra",  OP_SRA,  32'h8000_0000, 32'h24, 4'd1, 32'hF800_0000);
      issue_check("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1,  4'd2, 32'd0);
      issue_check("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1,  4'd3, 32'd1);
      issue_check("jalr", OP_JALR, 32'h1001,      32'h2,  4'd4, 32'h1002);
      issue_check("sub",  OP_SUB,  32'd5,         32'd7,  4'd5, 32'hFFFF_FFFE);
      issue_check("slli", OP_SLLI, 32'd1,         32'h3F, 4'd6, 32'h8000_0000);
      issue_check("srl",  OP_SRL,  32'h8000_0000, 32'd4,  4'd7, 32'h0800_0000);
      issue_check("xori", OP_XORI, 32'hF0F0_F0F0, 32'hFF, 4'd8, 32'hF0F0_F00F);
      issue_check("bgeu", OP_BGEU, 32'd3,         32'hFFFF_FFFF, 4'd9, 32'd0);
      issue_check("blt",  OP_BLT,  32'hFFFF_FFFE, 32'd2,  4'd10, 32'd1);

      // ---------------- fill to full ----------------
      bus.out_grant = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, OP_ADDI, 32'(i), 32'd100, 4'(i));
         chk($sformatf("fill%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
         tick();
      end
      drive(1'b1, OP_ADDI, 32'd4, 32'd100, 4'd4);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("full_count",    32'(bus.out_count), 32'd4);
      chk("full_head_rob", 32'(bus.out_rob),   32'd0);
      chk("full_head_ans", bus.out_ans,        32'd100);

      // push attempt + grant while full: only the pop happens
      bus.out_grant = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("full_pop_count",    32'(bus.out_count), 32'd3);
      chk("full_pop_in_ready", 32'(bus.in_ready),  32'd1);
      chk("full_pop_head_rob", 32'(bus.out_rob),   32'd1);
      chk("full_pop_head_ans", bus.out_ans,        32'd101);
      tick();
      chk("cnt2_count",    32'(bus.out_count), 32'd2);
      chk("cnt2_head_rob", 32'(bus.out_rob),   32'd2);

      // push and pop together at count 2
      drive(1'b1, OP_ADDI, 32'd5, 32'd100, 4'd5);
      tick();
      bus.in_valid = 1'b0;
      chk("pushpop_count",    32'(bus.out_count), 32'd2);
      chk("pushpop_head_rob", 32'(bus.out_rob),   32'd3);
      chk("pushpop_head_ans", bus.out_ans,        32'd103);
      tick();
      chk("drain_rob5", 32'(bus.out_rob), 32'd5);
      chk("drain_ans5", bus.out_ans,      32'd105);
      tick();
      chk("drain_empty_valid", 32'(bus.out_valid), 32'd0);
      chk("drain_empty_count", 32'(bus.out_count), 32'd0);

      // ---------------- flush ----------------
      bus.out_grant = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, OP_ADD, 32'(i), 32'd0, 4'(i));
         tick();
      end
      chk("preflush_count", 32'(bus.out_count), 32'd3);
      drive(1'b1, OP_ADD, 32'd77, 32'd0, 4'd7);
      flush_in      = 1'b1;
      bus.out_grant = 1'b1;
      tick();
      flush_in     = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_count", 32'(bus.out_count), 32'd0);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      tick();
      tick();
      chk("flush_stays_empty", 32'(bus.out_count), 32'd0);
      issue_check("post_flush", OP_ADD, 32'd20, 32'd22, 4'd11, 32'd42);

      // ---------------- rdy_in low ----------------
      bus.out_grant = 1'b0;
      drive(1'b1, OP_ADD, 32'd1, 32'd1, 4'd2);
      tick();
      chk("pause_pre_count", 32'(bus.out_count), 32'd1);
      rdy_in        = 1'b0;
      bus.out_grant = 1'b1;
      drive(1'b1, OP_ADD, 32'd3, 32'd3, 4'd4);
      #1;
      chk("pause_in_ready", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         flush_in = (i == 1);
         tick();
         chk($sformatf("pause%0d_count", i), 32'(bus.out_count), 32'd1);
         chk($sformatf("pause%0d_ans", i),   bus.out_ans,        32'd2);
         chk($sformatf("pause%0d_rob", i),   32'(bus.out_rob),   32'd2);
      end
      flush_in     = 1'b0;
      rdy_in       = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      chk("resume_pop_count", 32'(bus.out_count), 32'd0);

      issue_check("bne_eq", OP_BNE, 32'd4, 32'd4, 4'd6, 32'd0);

      drive(1'b1, 6'h3F, 32'd9, 32'd9, 4'hA);
      tick();
      bus.in_valid = 1'b0;
      chk("undef_valid", 32'(bus.out_valid), 32'd1);
      chk("undef_ans",   bus.out_ans,        32'd0);
      chk("undef_rob",   32'(bus.out_rob),   32'hA);
      chk("undef_op",    32'(bus.out_op),    32'h3F);
      tick();
      chk("final_empty", 32'(bus.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
